ext_bus_master: RTL and testbench
=================================

// Module: ext_bus_master
// PURPOSE
//  Parametrised successor to the single-transfer external-bus path of the memory manager.
//  Bridges core data-port accesses that decode as external (addr above local SRAM) onto the external bus.
//  Adds a posted-write buffer, read-after-write ordering, and a transfer_ok timeout with a bus-error pulse.
//  Sits between mem_ctrl and the chip-level external bus pins.
// PARAMETERS
//  ADDR_WIDTH      32    core address width
//  DATA_WIDTH      32    data width (multiple of 8)
//  EXT_ADDR_WIDTH  16    external address width; ext addr = req_addr[EXT_ADDR_WIDTH-1:0], masked
//  WBUF_DEPTH      4     posted-write entries, power of 2, >=2
//  TIMEOUT_CYCLES  255   max cycles waiting for transfer_ok, >=1
// PORTS
//  clk            in   1               clock
//  reset_n        in   1               async active-low reset
//  req_valid      in   1               external access requested; held while core_stall=1
//  req_we         in   1               1=write, 0=read
//  req_size       in   2               00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  req_addr       in   ADDR_WIDTH      byte address
//  req_wdata      in   DATA_WIDTH      write data, right-aligned
//  core_stall     out  1               core must hold request
//  rdata          out  DATA_WIDTH      read data, registered
//  rdata_valid    out  1               1-cycle pulse, read complete
//  bus_err        out  1               1-cycle pulse, transfer timed out
//  ext_active     out  1               external transfer in progress
//  ext_we         out  1               external write
//  ext_size       out  2               same encoding as req_size (11 never driven)
//  ext_addr_out   out  EXT_ADDR_WIDTH  external address
//  ext_val_out    out  DATA_WIDTH      external write data
//  ext_val_in     in   DATA_WIDTH      external read data, valid with transfer_ok
//  transfer_ok    in   1               slave completion, sampled on posedge clk
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO emptied, FSM to IDLE, timeout counter 0; applies at any time, mid-transfer included.
//  - Address mask: byte=none; half clears bit0; word/reserved clears bits[1:0].
//  - Writes posted:
//    - Accepted in the request cycle if the FIFO is not full (core_stall=0). The entry stores {masked addr, size, wdata}.
//    - FIFO full: core_stall=1 until a slot frees. The write is accepted in the cycle after the pop.
//  - Reads are ordered behind all buffered writes:
//    - core_stall=1 while the FIFO drains and while the read is outstanding.
//    - core_stall drops in the cycle rdata_valid=1; rdata = ext_val_in captured when transfer_ok was seen.
//  - FSM states:
//    - IDLE -> WR_BUS when the FIFO is non-empty (writes take priority).
//    - IDLE -> RD_BUS when the FIFO is empty and a read is pending.
//    - WR_BUS: transfer_ok -> pop, GAP. Timeout -> pop (write dropped), bus_err, GAP.
//    - RD_BUS: transfer_ok -> latch rdata, RD_DONE. Timeout -> rdata=0, bus_err, RD_DONE.
//    - RD_DONE: rdata_valid=1, core_stall=0 -> GAP.
//    - GAP: ext_active=0 for exactly 1 cycle -> IDLE.
//  - Bus timing:
//    - ext_* are registered and driven with ext_active=1 from the cycle after the WR_BUS/RD_BUS entry.
//    - They are held stable until transfer_ok is sampled, then drop with ext_active in GAP.
//  - Timeout: counter increments each cycle of WR_BUS/RD_BUS with ext_active=1. Reaching TIMEOUT_CYCLES without transfer_ok ends the transfer.
//  - transfer_ok outside WR_BUS/RD_BUS is ignored.
//  - Same cycle as a pop: a push on a full FIFO is not accepted (stall persists one more cycle).
//  - FIFO pointers wrap modulo WBUF_DEPTH; count width is clog2(WBUF_DEPTH)+1.
//  - No req_valid: core_stall=0.
// STRUCTURE
//  - Shared defines header ext_bus_defs.vh: size codes (SZ_BYTE/HALF/WORD), FSM state encodings, address-mask function.
//  - Sub-module ext_wbuf: synchronous FIFO (push, pop, full, empty, dout), same clk/reset_n.
//  - Top holds the FSM, timeout counter, output registers and stall logic.
// TESTING
//  - Write word 0xDEADBEEF to 0x0001_4003, slave acks after 2 cycles -> no stall; ext_addr_out=0x4000, ext_size=10, ext_we=1, one-cycle gap after ack.
//  - 5 back-to-back writes, WBUF_DEPTH=4, slave acks after 3 cycles -> 5th write stalls until first pop; bus order equals issue order.
//  - 2 writes then read half at 0x0000_C005 -> bus shows both writes, then read at 0xC004, ext_size=01; rdata=ext_val_in, core_stall low with rdata_valid.
//  - Read, no transfer_ok, TIMEOUT_CYCLES=8 -> bus_err pulse after 8 active cycles; rdata_valid with rdata=0; FSM returns to IDLE.
//  - Assert reset_n low during RD_BUS with 2 writes buffered -> all outputs 0 immediately; after release FIFO empty, ext_active=0.
//  - transfer_ok pulsed during GAP/IDLE -> no effect on FIFO, rdata or bus_err.

Source files
------------

// File: rtl/ext_bus_master_pkg.sv
// Shared encodings for the external-bus bridge: transfer sizes, FSM states, address-alignment helpers.
package ext_bus_master_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_BUS,
      ST_RD_BUS,
      ST_RD_DONE,
      ST_GAP
   } state_e;

   // The reserved size code behaves as a word everywhere, so it never reaches the pins.
   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      return (sz == SZ_RSVD) ? SZ_WORD : sz;
   endfunction

   function automatic logic [1:0] addr_lsb_mask(input logic [1:0] sz);
      case (norm_size(sz))
         SZ_BYTE: return 2'b00;
         SZ_HALF: return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/ext_wbuf.sv
// Synchronous FIFO for posted writes; dout shows the head entry combinationally.
// Push is ignored while full and pop while empty, so a push in the same cycle as a pop on a full FIFO is refused.
module ext_wbuf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage needs no reset: an empty FIFO never exposes its contents.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/ext_bus_master.sv
// Bridges external core accesses onto the external bus: posted writes, reads ordered behind them, timeout -> bus_err.
// Bus fields are registered on FSM entry; core_stall holds the core on a full FIFO or while a read is outstanding.
module ext_bus_master
   import ext_bus_master_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int EXT_ADDR_WIDTH = 16,
   parameter int WBUF_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      req_valid,
   input  logic                      req_we,
   input  logic [1:0]                req_size,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   output logic                      core_stall,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic                      rdata_valid,
   output logic                      bus_err,
   output logic                      ext_active,
   output logic                      ext_we,
   output logic [1:0]                ext_size,
   output logic [EXT_ADDR_WIDTH-1:0] ext_addr_out,
   output logic [DATA_WIDTH-1:0]     ext_val_out,
   input  logic [DATA_WIDTH-1:0]     ext_val_in,
   input  logic                      transfer_ok
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef struct packed {
      logic [EXT_ADDR_WIDTH-1:0] addr;
      logic [1:0]                size;
      logic [DATA_WIDTH-1:0]     data;
   } wentry_t;

   typedef struct packed {
      logic                      active;
      logic                      we;
      logic [1:0]                size;
      logic [EXT_ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]     val;
   } bus_t;

   function automatic logic [EXT_ADDR_WIDTH-1:0] mask_ext_addr(
      input logic [EXT_ADDR_WIDTH-1:0] a, input logic [1:0] sz);
      return a & ~{{(EXT_ADDR_WIDTH-2){1'b0}}, addr_lsb_mask(sz)};
   endfunction

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   bus_t                  bus_q, bus_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rdata_valid_q, rdata_valid_d;
   logic                  bus_err_q, bus_err_d;

   wentry_t wbuf_din, wbuf_dout;
   logic    wbuf_full, wbuf_empty;
   logic    wr_req, rd_req, bus_state, tmo, pop;
   logic    unused_addr_hi;

   assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:EXT_ADDR_WIDTH];

   assign wr_req    = req_valid && req_we;
   assign rd_req    = req_valid && !req_we;
   assign bus_state = (state_q == ST_WR_BUS) || (state_q == ST_RD_BUS);
   assign tmo       = bus_state && !transfer_ok && (cnt_q == TMO_LAST);
   assign pop       = (state_q == ST_WR_BUS) && (transfer_ok || tmo);

   assign wbuf_din = '{addr: mask_ext_addr(req_addr[EXT_ADDR_WIDTH-1:0], req_size),
                       size: norm_size(req_size),
                       data: req_wdata};

   ext_wbuf #(
      .WIDTH($bits(wentry_t)),
      .DEPTH(WBUF_DEPTH)
   ) u_wbuf (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (wr_req),
      .pop     (pop),
      .din     (wbuf_din),
      .dout    (wbuf_dout),
      .full    (wbuf_full),
      .empty   (wbuf_empty)
   );

   // Gated by reset_n so every output reads 0 the moment reset asserts.
   assign core_stall = reset_n && ((wr_req && wbuf_full) || (rd_req && state_q != ST_RD_DONE));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bus_d         = bus_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      bus_err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!wbuf_empty) begin
               state_d = ST_WR_BUS;
               bus_d   = '{active: 1'b1, we: 1'b1, size: wbuf_dout.size,
                           addr: wbuf_dout.addr, val: wbuf_dout.data};
            end else if (rd_req) begin
               state_d = ST_RD_BUS;
               bus_d   = '{active: 1'b1, we: 1'b0, size: norm_size(req_size),
                           addr: mask_ext_addr(req_addr[EXT_ADDR_WIDTH-1:0], req_size),
                           val: '0};
            end
         end
         ST_WR_BUS, ST_RD_BUS: begin
            if (transfer_ok || tmo) begin
               bus_d     = '0;
               cnt_d     = '0;
               bus_err_d = tmo;
               if (state_q == ST_WR_BUS) begin
                  state_d = ST_GAP;
               end else begin
                  state_d       = ST_RD_DONE;
                  rdata_valid_d = 1'b1;
                  rdata_d       = transfer_ok ? ext_val_in : '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RD_DONE: state_d = ST_GAP;
         ST_GAP:     state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         bus_q         <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         bus_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bus_q         <= bus_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         bus_err_q     <= bus_err_d;
      end
   end

   assign rdata        = rdata_q;
   assign rdata_valid  = rdata_valid_q;
   assign bus_err      = bus_err_q;
   assign ext_active   = bus_q.active;
   assign ext_we       = bus_q.we;
   assign ext_size     = bus_q.size;
   assign ext_addr_out = bus_q.addr;
   assign ext_val_out  = bus_q.val;

endmodule

// File: tb/tb_ext_bus_master.sv
// Directed + random bench for ext_bus_master: slave responder, bus monitor, expected-transaction queue.
module tb_ext_bus_master;

   localparam int AW = 32, DW = 32, EAW = 16, DEPTH = 4, TMO = 8;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           req_valid, req_we;
   logic [1:0]     req_size;
   logic [AW-1:0]  req_addr;
   logic [DW-1:0]  req_wdata;
   logic           core_stall, rdata_valid, bus_err, ext_active, ext_we;
   logic [DW-1:0]  rdata, ext_val_out, ext_val_in;
   logic [1:0]     ext_size;
   logic [EAW-1:0] ext_addr_out;
   logic           transfer_ok;

   always #5 clk = ~clk;

   ext_bus_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .EXT_ADDR_WIDTH(EAW),
      .WBUF_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .core_stall(core_stall), .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err),
      .ext_active(ext_active), .ext_we(ext_we), .ext_size(ext_size),
      .ext_addr_out(ext_addr_out), .ext_val_out(ext_val_out),
      .ext_val_in(ext_val_in), .transfer_ok(transfer_ok)
   );

   typedef struct {
      bit          we;
      int unsigned addr;
      int unsigned size;
      int unsigned data;
      int unsigned len;
   } txn_t;

   txn_t exp_q[$];
   txn_t obs_q[$];
   int   total = 0;
   int   bad = 0;

   // Slave: acks in active cycle lat+1; lat < 0 never acks. force_ok drives transfer_ok while idle.
   int          ack_lat = 0;
   bit          rand_lat = 1'b0;
   bit          force_ok = 1'b0;
   int          act_cnt = 0;
   int          cur_lat = 0;
   int unsigned last_ack_val = 0;

   initial begin
      transfer_ok = 1'b0;
      ext_val_in  = '0;
      forever begin
         @(negedge clk);
         if (ext_active) begin
            if (act_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 5)) : ack_lat;
            act_cnt++;
            if (cur_lat >= 0 && act_cnt == cur_lat + 1) begin
               ext_val_in   = $urandom;
               last_ack_val = ext_val_in;
               transfer_ok  = 1'b1;
            end else begin
               transfer_ok = 1'b0;
            end
         end else begin
            act_cnt     = 0;
            transfer_ok = force_ok;
         end
      end
   end

   // Monitor: one record per ext_active burst, with its length; counts bus_err pulses and field changes.
   int   err_cnt = 0;
   int   unstable = 0;
   bit   prev_act = 1'b0;
   txn_t cur;

   initial begin
      forever begin
         @(negedge clk);
         if (bus_err) err_cnt++;
         if (ext_active && !prev_act) begin
            cur.we   = ext_we;
            cur.addr = 32'(ext_addr_out);
            cur.size = 32'(ext_size);
            cur.data = ext_val_out;
            cur.len  = 1;
         end else if (ext_active) begin
            if (cur.we != ext_we || cur.addr != 32'(ext_addr_out) ||
                cur.size != 32'(ext_size) || cur.data != ext_val_out) unstable++;
            cur.len++;
         end else if (prev_act) begin
            obs_q.push_back(cur);
         end
         prev_act = ext_active;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int unsigned model_addr(int unsigned a, int unsigned sz);
      int unsigned e = a % 65536;
      if (sz == 1) return e - (e % 2);
      if (sz >= 2) return e - (e % 4);
      return e;
   endfunction

   function automatic int unsigned model_size(int unsigned sz);
      return (sz == 3) ? 2 : sz;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, 32'(core_stall), 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_rvalid"}, 32'(rdata_valid), 0);
      chk({tag, "_berr"}, 32'(bus_err), 0);
      chk({tag, "_active"}, 32'(ext_active), 0);
      chk({tag, "_we"}, 32'(ext_we), 0);
      chk({tag, "_size"}, 32'(ext_size), 0);
      chk({tag, "_addr"}, 32'(ext_addr_out), 0);
      chk({tag, "_val"}, ext_val_out, 0);
   endtask

   task automatic do_write(input int unsigned addr, input int unsigned sz,
                           input int unsigned data, output int stalls);
      txn_t t;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'(sz); req_addr = addr; req_wdata = data;
      #1;
      stalls = 0;
      while (core_stall && stalls < 200) begin tick(); stalls++; end
      chk("wr_accept", 32'(core_stall), 0);
      t.we = 1'b1; t.addr = model_addr(addr, sz); t.size = model_size(sz); t.data = data; t.len = 0;
      exp_q.push_back(t);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic do_read(input int unsigned addr, input int unsigned sz,
                          output int unsigned rd, output int stalls, output bit err);
      txn_t t;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'(sz); req_addr = addr; req_wdata = $urandom;
      t.we = 1'b0; t.addr = model_addr(addr, sz); t.size = model_size(sz); t.data = 0; t.len = 0;
      exp_q.push_back(t);
      #1;
      stalls = 0;
      while (core_stall && stalls < 300) begin tick(); stalls++; end
      chk("rd_release", 32'(core_stall), 0);
      chk("rd_valid_with_release", 32'(rdata_valid), 1);
      rd  = rdata;
      err = bus_err;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_ok(input string tag);
      int n = 0;
      while (!transfer_ok && n < 100) begin tick(); n++; end
      chk({tag, "_ok_seen"}, 32'(transfer_ok), 1);
      chk({tag, "_active_at_ok"}, 32'(ext_active), 1);
   endtask

   task automatic wait_idle();
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < 1000) begin
         tick();
         n++;
         quiet = ext_active ? 0 : quiet + 1;
      end
      chk("idle_reached", 32'(quiet), 4);
   endtask

   task automatic check_bus(input string tag);
      txn_t e, o;
      chk({tag, "_txn_count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk({tag, "_we"}, 32'(o.we), 32'(e.we));
         chk({tag, "_addr"}, o.addr, e.addr);
         chk({tag, "_size"}, o.size, e.size);
         if (e.we) chk({tag, "_data"}, o.data, e.data);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      int          st;
      int          st5[5];
      int unsigned rd, rd0;
      bit          err;
      int          err0;
      bit          seen;

      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
      repeat (3) tick();
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Single word write, acked in third active cycle, followed by a one-cycle gap.
      ack_lat = 2;
      do_write(32'h0001_4003, 2, 32'hDEAD_BEEF, st);
      chk("t1_no_stall", st, 0);
      wait_ok("t1");
      tick();
      chk("t1_gap_active", 32'(ext_active), 0);
      chk("t1_gap_addr", 32'(ext_addr_out), 0);
      wait_idle();
      check_bus("t1");

      // Five back-to-back writes into a four-entry buffer.
      ack_lat = 3;
      for (int i = 0; i < 5; i++) do_write($urandom, $urandom_range(0, 3), $urandom, st5[i]);
      for (int i = 0; i < 4; i++) chk("t2_no_stall", st5[i], 0);
      chk("t2_fifth_stalls", 32'(st5[4] > 0), 1);
      wait_idle();
      check_bus("t2");

      // Two writes then a half read that must wait behind them.
      ack_lat = 1;
      do_write($urandom, 2, $urandom, st);
      do_write($urandom, 0, $urandom, st);
      do_read(32'h0000_C005, 1, rd, st, err);
      chk("t3_rdata", rd, last_ack_val);
      chk("t3_no_err", 32'(err), 0);
      wait_idle();
      check_bus("t3");

      // Read with no slave response times out after TMO active cycles.
      ack_lat = -1;
      err0 = err_cnt;
      do_read(32'h0001_2346, 2, rd, st, err);
      chk("t4_rdata_zero", rd, 0);
      chk("t4_err_pulse", 32'(err), 1);
      wait_idle();
      chk("t4_err_count", err_cnt - err0, 1);
      if (obs_q.size() > 0) chk("t4_active_len", obs_q[0].len, TMO);
      check_bus("t4");
      err0 = err_cnt;
      do_write($urandom, 2, $urandom, st);
      wait_idle();
      chk("t4_wr_err_count", err_cnt - err0, 1);
      check_bus("t4w");
      ack_lat = 0;
      do_read($urandom, 3, rd, st, err);
      chk("t4_recover_rdata", rd, last_ack_val);
      wait_idle();
      check_bus("t4r");

      // Reset mid-transfer with writes buffered and a read waiting.
      ack_lat = -1;
      do_write($urandom, 2, $urandom, st);
      do_write($urandom, 2, $urandom, st);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = $urandom;
      repeat (3) tick();
      chk("t5_busy_before_reset", 32'(ext_active), 1);
      reset_n = 1'b0;
      #1;
      chk_all_zero("t5_reset");
      req_valid = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      obs_q.delete();
      exp_q.delete();
      seen = 1'b0;
      repeat (10) begin tick(); if (ext_active) seen = 1'b1; end
      chk("t5_fifo_empty_quiet", 32'(seen), 0);
      ack_lat = 0;
      do_write($urandom, 1, $urandom, st);
      wait_idle();
      check_bus("t5");

      // transfer_ok while not in a bus state is ignored.
      ack_lat = 1;
      rd0 = rdata;
      do_write($urandom, 0, $urandom, st);
      wait_ok("t6");
      force_ok = 1'b1;
      seen = 1'b0;
      repeat (4) begin tick(); if (bus_err || rdata_valid || ext_active) seen = 1'b1; end
      force_ok = 1'b0;
      chk("t6_no_effect", 32'(seen), 0);
      chk("t6_rdata_kept", rdata, rd0);
      do_read($urandom, 2, rd, st, err);
      chk("t6_rdata", rd, last_ack_val);
      wait_idle();
      check_bus("t6");

      // Random mix of reads and writes with random slave latency.
      rand_lat = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            do_read($urandom, $urandom_range(0, 3), rd, st, err);
            chk("rand_rdata", rd, last_ack_val);
            chk("rand_no_err", 32'(err), 0);
         end else begin
            do_write($urandom, $urandom_range(0, 3), $urandom, st);
         end
      end
      wait_idle();
      check_bus("rand");
      chk("ext_fields_stable", unstable, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
